// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with per-register pending-write counters.
// Readers stall on any in-flight writer; write-back bypasses into the read ports.
module regfile_scoreboard (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  input  logic        rs_used_i,
  input  logic        rt_used_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  input  logic        issue_valid_i,
  input  logic        issue_regwrite_i,
  input  logic [4:0]  issue_dst_i,
  input  logic        wb_regwrite_i,
  input  logic [4:0]  wb_dst_i,
  input  logic [31:0] wb_data_i,
  output logic        stall_o,
  output logic [31:0] busy_o,
  output logic        err_o
);

  logic [31:0] regFile_q [32];
  logic [1:0]  cnt_q [32];
  logic [1:0]  cnt_d [32];
  logic        err_q, err_d;

  logic        wr, iss;
  logic        rsHit, rtHit;
  logic [1:0]  effRs, effRt;
  logic        hzRs, hzRt;

  assign wr    = wb_regwrite_i & (wb_dst_i != 5'd0);
  assign rsHit = wr & (wb_dst_i == rs_addr_i);
  assign rtHit = wr & (wb_dst_i == rt_addr_i);

  assign rs_data_o = (rs_addr_i == 5'd0) ? 32'd0 :
                     rsHit ? wb_data_i : regFile_q[rs_addr_i];
  assign rt_data_o = (rt_addr_i == 5'd0) ? 32'd0 :
                     rtHit ? wb_data_i : regFile_q[rt_addr_i];

  // A retiring write to the operand frees one count this very cycle.
  assign effRs   = cnt_q[rs_addr_i] - {1'b0, rsHit};
  assign effRt   = cnt_q[rt_addr_i] - {1'b0, rtHit};
  assign hzRs    = rs_used_i & (rs_addr_i != 5'd0) & (effRs != 2'd0);
  assign hzRt    = rt_used_i & (rt_addr_i != 5'd0) & (effRt != 2'd0);
  assign stall_o = hzRs | hzRt;

  assign iss = issue_valid_i & ~stall_o & issue_regwrite_i & (issue_dst_i != 5'd0);

  always_comb begin
    for (int n = 0; n < 32; n++) cnt_d[n] = cnt_q[n];
    err_d = err_q;
    // Issue and retire to the same register cancel; otherwise they touch distinct counters.
    if (!(iss && wr && (issue_dst_i == wb_dst_i))) begin
      if (iss) begin
        if (cnt_q[issue_dst_i] == 2'd3) err_d = 1'b1;
        else cnt_d[issue_dst_i] = cnt_q[issue_dst_i] + 2'd1;
      end
      if (wr) begin
        if (cnt_q[wb_dst_i] == 2'd0) err_d = 1'b1;
        else cnt_d[wb_dst_i] = cnt_q[wb_dst_i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < 32; n++) begin
        regFile_q[n] <= 32'd0;
        cnt_q[n]     <= 2'd0;
      end
      err_q <= 1'b0;
    end else begin
      if (wr) regFile_q[wb_dst_i] <= wb_data_i;
      for (int n = 0; n < 32; n++) cnt_q[n] <= cnt_d[n];
      err_q <= err_d;
    end
  end

  always_comb begin
    busy_o = 32'd0;
    for (int n = 1; n < 32; n++) busy_o[n] = (cnt_q[n] != 2'd0);
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard: combinational outputs checked mid-cycle,
// registered busy/err expectations queued at drive time and popped after the edge.
module tb_regfile_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [4:0]  rs_addr_i, rt_addr_i, issue_dst_i, wb_dst_i;
  logic        rs_used_i, rt_used_i, issue_valid_i, issue_regwrite_i, wb_regwrite_i;
  logic [31:0] wb_data_i, rs_data_o, rt_data_o, busy_o;
  logic        stall_o, err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rs, rt, issDst, wbDst;
    logic        rsUsed, rtUsed, issValid, issRw, wbRw;
    logic [31:0] wbData;
    logic [31:0] expRs, expRt;
    logic        expStall;
    logic [31:0] expBusy;
    logic        expErr;
  } vec_t;

  typedef struct packed {
    logic [31:0] busy;
    logic        err;
  } post_t;

  vec_t  vecs [17];
  vec_t  errVecs [6];
  post_t postQ [$];

  regfile_scoreboard dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rs_used_i(rs_used_i), .rt_used_i(rt_used_i),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
    .issue_valid_i(issue_valid_i), .issue_regwrite_i(issue_regwrite_i),
    .issue_dst_i(issue_dst_i),
    .wb_regwrite_i(wb_regwrite_i), .wb_dst_i(wb_dst_i), .wb_data_i(wb_data_i),
    .stall_o(stall_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic [4:0] rs, input logic rsU, input logic [4:0] rt,
                              input logic rtU, input logic issV, input logic issRw,
                              input logic [4:0] issD, input logic wbRw, input logic [4:0] wbD,
                              input logic [31:0] wbData, input logic [31:0] eRs,
                              input logic [31:0] eRt, input logic eStall,
                              input logic [31:0] eBusy, input logic eErr);
    vec_t v;
    v.rs = rs; v.rsUsed = rsU; v.rt = rt; v.rtUsed = rtU;
    v.issValid = issV; v.issRw = issRw; v.issDst = issD;
    v.wbRw = wbRw; v.wbDst = wbD; v.wbData = wbData;
    v.expRs = eRs; v.expRt = eRt; v.expStall = eStall;
    v.expBusy = eBusy; v.expErr = eErr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic zeroInputs();
    rs_addr_i = 0; rt_addr_i = 0; rs_used_i = 0; rt_used_i = 0;
    issue_valid_i = 0; issue_regwrite_i = 0; issue_dst_i = 0;
    wb_regwrite_i = 0; wb_dst_i = 0; wb_data_i = 0;
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    post_t p;
    @(negedge clk_i);
    rs_addr_i = v.rs; rt_addr_i = v.rt; rs_used_i = v.rsUsed; rt_used_i = v.rtUsed;
    issue_valid_i = v.issValid; issue_regwrite_i = v.issRw; issue_dst_i = v.issDst;
    wb_regwrite_i = v.wbRw; wb_dst_i = v.wbDst; wb_data_i = v.wbData;
    postQ.push_back('{busy: v.expBusy, err: v.expErr});
    #1;
    checkOutput({tag, " rs_data"}, rs_data_o, v.expRs);
    checkOutput({tag, " rt_data"}, rt_data_o, v.expRt);
    checkOutput({tag, " stall"}, {31'd0, stall_o}, {31'd0, v.expStall});
    @(posedge clk_i);
    #1;
    if (postQ.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL %s queue: got empty, expected entry", tag);
    end else begin
      p = postQ.pop_front();
      checkOutput({tag, " busy"}, busy_o, p.busy);
      checkOutput({tag, " err"}, {31'd0, err_o}, {31'd0, p.err});
    end
    zeroInputs();
  endtask

  // Drops reset away from any clock edge and checks the state clears without a clock.
  task automatic asyncReset(input string tag);
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput({tag, " rst busy"}, busy_o, 32'd0);
    checkOutput({tag, " rst err"}, {31'd0, err_o}, 32'd0);
    checkOutput({tag, " rst stall"}, {31'd0, stall_o}, 32'd0);
    checkOutput({tag, " rst rs_data"}, rs_data_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin
    zeroInputs();
    rst_n_i = 1'b0;
    #1;
    checkOutput("init busy", busy_o, 32'd0);
    checkOutput("init err", {31'd0, err_o}, 32'd0);
    checkOutput("init stall", {31'd0, stall_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    //            rs rsU rt rtU iV iRw iD wRw wD  wData         eRs           eRt           eSt eBusy    eErr
    vecs[0]  = mk(0, 0, 0, 0, 1, 1, 8,  0, 0,  32'h0,        32'h0,        32'h0,        0, 32'h100,  0);
    vecs[1]  = mk(8, 1, 0, 0, 0, 0, 0,  1, 8,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 32'h0,    0);
    vecs[2]  = mk(8, 1, 0, 0, 0, 0, 0,  0, 0,  32'h0,        32'hDEADBEEF, 32'h0,        0, 32'h0,    0);
    vecs[3]  = mk(0, 0, 8, 1, 1, 1, 9,  0, 0,  32'h0,        32'h0,        32'hDEADBEEF, 0, 32'h200,  0);
    vecs[4]  = mk(0, 0, 9, 1, 1, 1, 10, 0, 0,  32'h0,        32'h0,        32'h0,        1, 32'h200,  0);
    vecs[5]  = mk(0, 0, 9, 1, 1, 1, 10, 0, 0,  32'h0,        32'h0,        32'h0,        1, 32'h200,  0);
    vecs[6]  = mk(0, 0, 9, 1, 1, 1, 10, 1, 9,  32'h999,      32'h0,        32'h999,      0, 32'h400,  0);
    vecs[7]  = mk(0, 1, 0, 0, 1, 1, 0,  1, 10, 32'hA,        32'h0,        32'h0,        0, 32'h0,    0);
    vecs[8]  = mk(0, 1, 0, 0, 0, 0, 0,  1, 0,  32'h1234,     32'h0,        32'h0,        0, 32'h0,    0);
    vecs[9]  = mk(0, 0, 0, 0, 1, 1, 4,  0, 0,  32'h0,        32'h0,        32'h0,        0, 32'h10,   0);
    vecs[10] = mk(0, 0, 0, 0, 1, 1, 4,  0, 0,  32'h0,        32'h0,        32'h0,        0, 32'h10,   0);
    vecs[11] = mk(4, 1, 0, 0, 0, 0, 0,  1, 4,  32'h44,       32'h44,       32'h0,        1, 32'h10,   0);
    vecs[12] = mk(4, 1, 0, 0, 0, 0, 0,  0, 0,  32'h0,        32'h44,       32'h0,        1, 32'h10,   0);
    vecs[13] = mk(4, 1, 0, 0, 0, 0, 0,  1, 4,  32'h55,       32'h55,       32'h0,        0, 32'h0,    0);
    vecs[14] = mk(0, 0, 0, 0, 1, 1, 5,  0, 0,  32'h0,        32'h0,        32'h0,        0, 32'h20,   0);
    vecs[15] = mk(0, 0, 0, 0, 1, 1, 5,  1, 5,  32'h5,        32'h0,        32'h0,        0, 32'h20,   0);
    vecs[16] = mk(0, 0, 0, 0, 1, 1, 5,  0, 0,  32'h0,        32'h0,        32'h0,        0, 32'h20,   0);

    for (int i = 0; i < 17; i++) applyStimulus($sformatf("v%0d", i), vecs[i]);

    // Mid-stream reset with two writers pending on r5.
    @(negedge clk_i);
    rs_addr_i = 5; rs_used_i = 1;
    #1;
    checkOutput("pre-rst rs_data", rs_data_o, 32'h5);
    checkOutput("pre-rst stall", {31'd0, stall_o}, 32'd1);
    checkOutput("pre-rst busy", busy_o, 32'h20);
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("rst rs_data", rs_data_o, 32'd0);
    checkOutput("rst stall", {31'd0, stall_o}, 32'd0);
    checkOutput("rst busy", busy_o, 32'd0);
    checkOutput("rst err", {31'd0, err_o}, 32'd0);
    @(negedge clk_i);
    zeroInputs();
    rst_n_i = 1'b1;

    // Overflow: the fourth issue to r3 saturates and flags.
    errVecs[0] = mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 32'h0,  32'h0,  32'h0,  0, 32'h8, 0);
    errVecs[1] = mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 32'h0,  32'h0,  32'h0,  0, 32'h8, 0);
    errVecs[2] = mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 32'h0,  32'h0,  32'h0,  0, 32'h8, 0);
    errVecs[3] = mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 32'h0,  32'h0,  32'h0,  0, 32'h8, 1);
    // Underflow: retire to idle r7 still writes the data.
    errVecs[4] = mk(7, 0, 0, 0, 0, 0, 0, 1, 7, 32'h77, 32'h77, 32'h0,  0, 32'h0, 1);
    errVecs[5] = mk(7, 0, 7, 1, 0, 0, 0, 0, 0, 32'h0,  32'h77, 32'h77, 0, 32'h0, 1);

    for (int i = 0; i < 4; i++) applyStimulus($sformatf("ovf%0d", i), errVecs[i]);
    asyncReset("ovf");
    for (int i = 4; i < 6; i++) applyStimulus($sformatf("unf%0d", i - 4), errVecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
